pc_seq_ctrl: RTL and testbench
==============================

# pc_seq_ctrl

Fetch-sequencing controller for the five-stage pipeline. Owns the PC register and applies the redirect from the ID-stage next-PC unit (jump or taken branch), load-use stalls from the hazard unit, and syscall halt with resume and single-step. It drives the IF/ID and ID/EX pipeline-register enables and clears, and keeps performance counters for the FPGA display.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 32, width of every performance counter
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- npc  in  32  redirect target from the next-PC unit (ID stage)
- jmp  in  1  unconditional jump (j/jal/jr) in ID
- correct_b  in  1  conditional branch in ID resolved taken
- load_use  in  1  hazard unit: ID instruction needs a load result still in EX
- halt  in  1  syscall-halt instruction in ID
- go  in  1  one-cycle resume pulse (debounced button)
- step_mode  in  1  1: go advances one cycle only
- pc  out  32  fetch address (registered)
- ifid_en  out  1  IF/ID register load enable
- ifid_clr  out  1  IF/ID clear (insert bubble), wins over ifid_en
- idex_clr  out  1  ID/EX clear (insert bubble)
- halted  out  1  state is HALT
- cyc_cnt, stall_cnt, taken_cnt, jmp_cnt  out  CNT_W  performance counters

## Operation
- States: RUN, HALT, STEP. Reset state is RUN.
- "Active" means the state is RUN or STEP. In an active cycle the inputs are evaluated in this priority order:
  1. load_use: pc holds, ifid_en=0, idex_clr=1, stall_cnt+1. Any redirect or halt in that cycle is ignored. The ID instruction is held and re-evaluated next cycle.
  2. halt: pc holds, ifid_clr=1 (drops the instruction fetched after the syscall). idex_clr=0, so the syscall proceeds to EX. Next state is HALT.
  3. jmp or correct_b: pc<=npc, ifid_clr=1 (drops the wrong-path fetch). jmp_cnt+1 if jmp, else taken_cnt+1. Both inputs high counts as jmp.
  4. Otherwise: pc<=pc+4, ifid_en=1, clears 0.
- STEP: one active cycle, evaluated exactly as above, then HALT. If that cycle sees halt, it still goes to HALT.
- HALT:
  - pc holds, ifid_en=0, ifid_clr=0, idex_clr=1, so downstream drains with bubbles.
  - go=1 with step_mode=0: next state RUN.
  - go=1 with step_mode=1: next state STEP.
  - Inputs other than go and step_mode are ignored.
- Counters:
  - cyc_cnt+1 on every active cycle. All counters freeze in HALT.
  - All counters wrap modulo 2^CNT_W.
- pc arithmetic is modulo 2^32; the wrap from 32'hFFFF_FFFC goes to 0. npc is loaded unmodified (no alignment forcing).
- rst in any state, including mid-stall or in HALT: state RUN, pc=RESET_PC, all counters 0.

## Timing
- Reset values: pc=RESET_PC, halted=0, all counters 0.
  - The first cycle after reset is RUN, so ifid_en=1, ifid_clr=0, idex_clr=0 (unless load_use).
- pc, state and counters are registered. ifid_en, ifid_clr, idex_clr and halted are combinational from the current state and current inputs.
- Redirect seen in cycle N: ifid_clr=1 in N, pc=npc in N+1. Penalty is exactly one bubble.
- load_use high for k cycles: pc is constant for those k cycles and resumes the next cycle. stall_cnt increases by k.
- halt seen in cycle N: halted=1 from N+1, and pc holds the address after the syscall.
- go in HALT at cycle M:
  - step_mode=0: RUN at M+1.
  - step_mode=1: STEP at M+1, HALT at M+2, pc advanced by one step.
- go while active: ignored.

## Structure
- Shared pipeline package holds:
  - state encoding localparams: ST_RUN=2'd0, ST_HALT=2'd1, ST_STEP=2'd2
  - PC_INC=32'd4
  - reset-vector constant shared with the instruction memory
- One natural sub-module: perf_counter (CNT_W-bit, synchronous clear, enable, wrapping). Instantiate it four times.
- FSM, PC register and priority logic stay in pc_seq_ctrl.

## Test plan
- Sequential fetch: release reset with RESET_PC=0 and no events for 4 cycles. Required: pc=0,4,8,12; cyc_cnt=4.
- Redirect: jmp=1, npc=32'h40 in one cycle. Required: ifid_clr=1 in that cycle, pc=32'h40 next cycle, jmp_cnt=1. Repeat with correct_b: taken_cnt=1.
- Stall beats redirect: load_use=1 and correct_b=1 together for 2 cycles, then correct_b alone. Required: pc frozen 2 cycles, stall_cnt=2, then pc=npc, taken_cnt=1.
- Halt and resume: halt at pc=32'h20. Required:
  - halted=1 next cycle, pc=32'h20 held, counters frozen for 10 cycles.
  - go with step_mode=0: RUN, pc=32'h24 the cycle after.
- Single step: in HALT with step_mode=1, apply 3 go pulses spaced apart. Required: pc advances by 4 per pulse, halted re-asserts after each step, cyc_cnt+3.
- Reset mid-operation: rst asserted in HALT and again during load_use. Required: next cycle state RUN, pc=RESET_PC, all counters 0. Also check pc wrap from 32'hFFFF_FFFC to 0.

Source files
------------

// File: rtl/pc_seq_ctrl_pkg.sv
// Shared pipeline definitions: fetch-sequencer state encoding, PC step and the
// reset vector that the instruction memory also starts from.
package pc_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [31:0] PC_INC       = 32'd4;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_seq_ctrl_perf_counter.sv
// Wrapping performance counter with synchronous clear and count enable.
module perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch sequencer: owns the PC, applies redirects, load-use stalls and
// syscall halt / resume / single-step, and drives the IF/ID and ID/EX controls.
module pc_seq_ctrl
    import pc_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      npc,
    input  logic             jmp,
    input  logic             correct_b,
    input  logic             load_use,
    input  logic             halt,
    input  logic             go,
    input  logic             step_mode,
    output logic [31:0]      pc,
    output logic             ifid_en,
    output logic             ifid_clr,
    output logic             idex_clr,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] jmp_cnt
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_nxt;
    logic        cyc_en;
    logic        stall_en;
    logic        taken_en;
    logic        jmp_en;

    // Priority among stall, halt and redirect in an active (RUN/STEP) cycle.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc + PC_INC;
        ifid_en   = 1'b1;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        cyc_en    = 1'b0;
        stall_en  = 1'b0;
        taken_en  = 1'b0;
        jmp_en    = 1'b0;
        case (state)
            ST_HALT: begin
                pc_nxt   = pc;
                ifid_en  = 1'b0;
                idex_clr = 1'b1;
                if (go) begin
                    state_nxt = step_mode ? ST_STEP : ST_RUN;
                end
            end
            default: begin
                cyc_en    = 1'b1;
                state_nxt = (state == ST_STEP) ? ST_HALT : ST_RUN;
                if (load_use) begin
                    pc_nxt   = pc;
                    ifid_en  = 1'b0;
                    idex_clr = 1'b1;
                    stall_en = 1'b1;
                end else if (halt) begin
                    pc_nxt    = pc;
                    ifid_clr  = 1'b1;
                    state_nxt = ST_HALT;
                end else if (jmp || correct_b) begin
                    pc_nxt   = npc;
                    ifid_clr = 1'b1;
                    jmp_en   = jmp;
                    taken_en = ~jmp;
                end
            end
        endcase
    end

    assign halted = (state == ST_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    perf_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk (clk),
        .rst (rst),
        .en  (cyc_en),
        .cnt (cyc_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (stall_en),
        .cnt (stall_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk (clk),
        .rst (rst),
        .en  (taken_en),
        .cnt (taken_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_jmp_cnt (
        .clk (clk),
        .rst (rst),
        .en  (jmp_en),
        .cnt (jmp_cnt)
    );

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: directed scenarios followed by random
// traffic, each cycle's expected outputs queued from a behavioural model.
module tb_pc_seq_ctrl;

    localparam int unsigned CW  = 8;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int unsigned CNT_MOD = 1 << CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   npc = '0;
    logic          jmp = 1'b0;
    logic          correct_b = 1'b0;
    logic          load_use = 1'b0;
    logic          halt = 1'b0;
    logic          go = 1'b0;
    logic          step_mode = 1'b0;
    logic [31:0]   pc;
    logic          ifid_en;
    logic          ifid_clr;
    logic          idex_clr;
    logic          halted;
    logic [CW-1:0] cyc_cnt;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] taken_cnt;
    logic [CW-1:0] jmp_cnt;

    always #5 clk = ~clk;

    pc_seq_ctrl #(
        .RESET_PC (RPC),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .npc       (npc),
        .jmp       (jmp),
        .correct_b (correct_b),
        .load_use  (load_use),
        .halt      (halt),
        .go        (go),
        .step_mode (step_mode),
        .pc        (pc),
        .ifid_en   (ifid_en),
        .ifid_clr  (ifid_clr),
        .idex_clr  (idex_clr),
        .halted    (halted),
        .cyc_cnt   (cyc_cnt),
        .stall_cnt (stall_cnt),
        .taken_cnt (taken_cnt),
        .jmp_cnt   (jmp_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        bit          en;
        bit          clr;
        bit          idex;
        bit          hlt;
        int unsigned cyc;
        int unsigned stl;
        int unsigned tkn;
        int unsigned jc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: machine-level view of the sequencer.
    bit          m_known = 1'b0;
    bit          m_halted;
    bit          m_stepping;
    logic [31:0] m_pc;
    int unsigned m_cyc, m_stl, m_tkn, m_jc;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endfunction

    task automatic cyc(input bit r, input bit j, input bit b, input bit l,
                       input bit h, input bit g, input bit s, input logic [31:0] n);
        exp_t e;
        @(negedge clk);
        rst = r; jmp = j; correct_b = b; load_use = l;
        halt = h; go = g; step_mode = s; npc = n;
        #1;
        if (m_known) begin
            e.pc  = m_pc;
            e.hlt = m_halted;
            e.cyc = m_cyc; e.stl = m_stl; e.tkn = m_tkn; e.jc = m_jc;
            if (m_halted || l) begin
                e.en = 1'b0; e.clr = 1'b0; e.idex = 1'b1;
            end else if (h || j || b) begin
                e.en = 1'b1; e.clr = 1'b1; e.idex = 1'b0;
            end else begin
                e.en = 1'b1; e.clr = 1'b0; e.idex = 1'b0;
            end
            exp_q.push_back(e);
        end
        if (r) begin
            m_known = 1'b1; m_halted = 1'b0; m_stepping = 1'b0; m_pc = RPC;
            m_cyc = 0; m_stl = 0; m_tkn = 0; m_jc = 0;
        end else if (m_known) begin
            if (m_halted) begin
                if (g) begin
                    m_halted   = 1'b0;
                    m_stepping = s;
                end
            end else begin
                m_cyc = (m_cyc + 1) % CNT_MOD;
                if (l) begin
                    m_stl = (m_stl + 1) % CNT_MOD;
                end else if (h) begin
                    m_halted = 1'b1;
                end else if (j || b) begin
                    m_pc = n;
                    if (j) m_jc = (m_jc + 1) % CNT_MOD;
                    else   m_tkn = (m_tkn + 1) % CNT_MOD;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
                if (m_stepping) begin
                    m_stepping = 1'b0;
                    m_halted   = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int unsigned k);
        for (int unsigned i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", pc, e.pc);
                if (!e.clr) chk("ifid_en", 32'(ifid_en), 32'(e.en));
                chk("ifid_clr", 32'(ifid_clr), 32'(e.clr));
                chk("idex_clr", 32'(idex_clr), 32'(e.idex));
                chk("halted", 32'(halted), 32'(e.hlt));
                chk("cyc_cnt", 32'(cyc_cnt), e.cyc);
                chk("stall_cnt", 32'(stall_cnt), e.stl);
                chk("taken_cnt", 32'(taken_cnt), e.tkn);
                chk("jmp_cnt", 32'(jmp_cnt), e.jc);
            end
        end
    end

    initial begin : driver
        cyc(1, 0, 0, 0, 0, 0, 0, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, 32'h0);
        idle(5);
        // Redirects
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h40);
        idle(2);
        cyc(0, 0, 1, 0, 0, 0, 0, 32'h80);
        idle(2);
        cyc(0, 1, 1, 0, 0, 0, 0, 32'h3);
        idle(1);
        // Stall beats redirect
        cyc(0, 0, 1, 1, 0, 0, 0, 32'h100);
        cyc(0, 0, 1, 1, 0, 0, 0, 32'h100);
        cyc(0, 0, 1, 0, 0, 0, 0, 32'h100);
        idle(2);
        // Halt at 0x20, junk ignored while halted, then resume
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h20);
        cyc(0, 0, 0, 0, 1, 0, 0, 32'h0);
        for (int unsigned i = 0; i < 10; i++) cyc(0, 1, 1, 1, 1, 0, 0, 32'h55);
        cyc(0, 0, 0, 0, 0, 1, 0, 32'h0);
        idle(3);
        // Single step
        cyc(0, 0, 0, 0, 1, 0, 0, 32'h0);
        for (int unsigned p = 0; p < 3; p++) begin
            idle(2);
            cyc(0, 0, 0, 0, 0, 1, 1, 32'h0);
        end
        idle(3);
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h0);
        cyc(0, 0, 0, 0, 1, 0, 0, 32'h0);
        idle(2);
        cyc(0, 0, 0, 0, 0, 1, 0, 32'h0);
        idle(2);
        // Reset in HALT and during load_use
        cyc(0, 0, 0, 0, 1, 0, 0, 32'h0);
        idle(2);
        cyc(1, 0, 0, 0, 0, 0, 0, 32'h0);
        idle(3);
        cyc(0, 0, 0, 1, 0, 0, 0, 32'h0);
        cyc(1, 0, 0, 1, 0, 0, 0, 32'h0);
        idle(2);
        // PC wrap
        cyc(0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
        idle(3);
        // Random traffic, long enough for the counters to wrap
        for (int unsigned i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)),
                $urandom());
        end
        idle(2);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
